// File: rtl/helios_host_sequencer_pkg.sv
// Shared constants and types for the Helios host sequencer: the protocol
// marker bytes sent to the decoder, the sequencer state encoding, and a small
// helper used to size byte counters.
package helios_host_sequencer_pkg;

   // Marker that tells the decoder a new decoding session begins.
   localparam logic [7:0] START_DECODING_MSG      = 8'h01;
   // Marker that precedes every block of measurement payload bytes.
   localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SEND_START = 3'd1,
      ST_SEND_HDR   = 3'd2,
      ST_SEND_MEAS  = 3'd3,
      ST_WAIT_RESP  = 3'd4,
      ST_RECV_STATS = 3'd5,
      ST_RECV_CORR  = 3'd6
   } seq_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/helios_host_sequencer.sv
// Helios host sequencer: streams one test (optional START, HEADER, measurement
// payload) into the decoder input FIFO, then collects the decoder response
// (iteration count, 16-bit cycle count big-endian, correction bytes) and
// publishes per-test statistics.
//
// Optional feature, enabled by defining SEQ_TIMEOUT_EN: a response watchdog
// that abandons the test after TIMEOUT_CYCLES cycles without an rx byte and
// pulses timeout_o. Without the macro the sequencer waits indefinitely.
//
// Handshake semantics (all channels): a byte transfers on the rising clock
// edge of a cycle in which both valid and ready are high; a valid seen with
// ready low transfers nothing and the source must hold its byte.
module helios_host_sequencer
   import helios_host_sequencer_pkg::*;
#(
   parameter int unsigned MEAS_BYTES     = 18,
   parameter int unsigned CORR_BYTES     = 42,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        run_i,
   input  logic [7:0]  meas_data_i,
   input  logic        meas_valid_i,
   output logic        meas_ready_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic [7:0]  corr_data_o,
   output logic        corr_valid_o,
   output logic [7:0]  iteration_count_o,
   output logic [15:0] cycle_count_o,
   output logic        result_valid_o,
   output logic [31:0] test_count_o,
   output logic        busy_o,
`ifdef SEQ_TIMEOUT_EN
   output logic        timeout_o,
`endif
   output seq_state_e  state_o
);

   localparam int unsigned MAX_BYTES = max_u(MEAS_BYTES, CORR_BYTES);
   localparam int unsigned CNT_W     = $clog2(MAX_BYTES + 1);

   // Degenerate sizes would collapse counter widths to zero.
   if (MEAS_BYTES < 1 || CORR_BYTES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("helios_host_sequencer: MEAS_BYTES/CORR_BYTES must be >= 1 and TIMEOUT_CYCLES >= 2");
   end

   seq_state_e        state_q;
   logic              first_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [7:0]        iter_q;
   logic [15:0]       cyc_q;
   logic [31:0]       test_count_q;
   logic              result_valid_q;
   logic              corr_valid_q;
   logic [7:0]        corr_data_q;
   logic              in_rx;
   logic              tx_xfer;
   logic              rx_xfer;

`ifdef SEQ_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
   logic [TMO_W-1:0]  tmo_q;
   logic              timeout_q;
   assign timeout_o = timeout_q;
`endif

   assign in_rx   = (state_q == ST_WAIT_RESP) || (state_q == ST_RECV_STATS) ||
                    (state_q == ST_RECV_CORR);
   assign rx_ready_o = in_rx;
   assign tx_xfer = tx_valid_o & tx_ready_i;
   assign rx_xfer = rx_valid_i & rx_ready_o;

   // Steer the tx and meas handshakes: fixed markers, or payload pass-through.
   always_comb begin
      tx_data_o    = 8'h00;
      tx_valid_o   = 1'b0;
      meas_ready_o = 1'b0;
      case (state_q)
         ST_SEND_START: begin
            tx_data_o  = START_DECODING_MSG;
            tx_valid_o = 1'b1;
         end
         ST_SEND_HDR: begin
            tx_data_o  = MEASUREMENT_DATA_HEADER;
            tx_valid_o = 1'b1;
         end
         ST_SEND_MEAS: begin
            tx_data_o    = meas_data_i;
            tx_valid_o   = meas_valid_i;
            meas_ready_o = tx_ready_i;
         end
         default: ;
      endcase
   end

   // Sequencer FSM with its byte counter, statistics and registered pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= ST_IDLE;
         first_q        <= 1'b1;
         cnt_q          <= '0;
         iter_q         <= 8'h00;
         cyc_q          <= 16'h0000;
         test_count_q   <= 32'h0;
         result_valid_q <= 1'b0;
         corr_valid_q   <= 1'b0;
         corr_data_q    <= 8'h00;
`ifdef SEQ_TIMEOUT_EN
         tmo_q          <= '0;
         timeout_q      <= 1'b0;
`endif
      end else begin
         result_valid_q <= 1'b0;
         corr_valid_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (run_i) begin
                  // Only the first test after reset opens a decoding session.
                  state_q <= first_q ? ST_SEND_START : ST_SEND_HDR;
                  first_q <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            ST_SEND_START: begin
               if (tx_xfer) begin
                  state_q <= ST_SEND_HDR;
                  cnt_q   <= '0;
               end
            end
            ST_SEND_HDR: begin
               if (tx_xfer) begin
                  state_q <= ST_SEND_MEAS;
                  cnt_q   <= '0;
               end
            end
            ST_SEND_MEAS: begin
               if (tx_xfer) begin
                  if (cnt_q == CNT_W'(MEAS_BYTES - 1)) begin
                     state_q <= ST_WAIT_RESP;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_WAIT_RESP: begin
               if (rx_xfer) begin
                  iter_q  <= rx_data_i;
                  state_q <= ST_RECV_STATS;
                  cnt_q   <= '0;
               end
            end
            ST_RECV_STATS: begin
               if (rx_xfer) begin
                  if (cnt_q == '0) begin
                     cyc_q[15:8] <= rx_data_i;
                     cnt_q       <= CNT_W'(1);
                  end else begin
                     cyc_q[7:0] <= rx_data_i;
                     state_q    <= ST_RECV_CORR;
                     cnt_q      <= '0;
                  end
               end
            end
            ST_RECV_CORR: begin
               if (rx_xfer) begin
                  corr_valid_q <= 1'b1;
                  corr_data_q  <= rx_data_i;
                  if (cnt_q == CNT_W'(CORR_BYTES - 1)) begin
                     state_q        <= ST_IDLE;
                     cnt_q          <= '0;
                     result_valid_q <= 1'b1;
                     test_count_q   <= test_count_q + 32'd1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
`ifdef SEQ_TIMEOUT_EN
         // Watchdog: any rx byte restarts it; expiry abandons the test quietly.
         timeout_q <= 1'b0;
         if (!in_rx || rx_xfer) begin
            tmo_q <= '0;
         end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
         end else begin
            tmo_q <= tmo_q + TMO_W'(1);
         end
`endif
      end
   end

   assign corr_data_o       = corr_data_q;
   assign corr_valid_o      = corr_valid_q;
   assign iteration_count_o = iter_q;
   assign cycle_count_o     = cyc_q;
   assign result_valid_o    = result_valid_q;
   assign test_count_o      = test_count_q;
   assign busy_o            = (state_q != ST_IDLE);
   assign state_o           = state_q;

endmodule
